// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch front end. Owns the fetch PC, issues in-order
//            requests to instruction memory, buffers responses in a small
//            circular queue and presents {pc, instr} to decode. Honours the
//            decode stall and drops stale fetches after a branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [INS_W-1:0] imem_rsp_data,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  rsp_pc_q,   rsp_pc_d;
  logic [CNT_W-1:0] outst_q,    outst_d;
  logic [CNT_W-1:0] drop_q,     drop_d;
  logic [CNT_W-1:0] occ_q,      occ_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PC_W-1:0]  out_pc_q,   out_pc_d;
  logic [INS_W-1:0] out_ins_q,  out_ins_d;

  logic [PC_W-1:0]  pc_mem_q  [DEPTH];
  logic [INS_W-1:0] ins_mem_q [DEPTH];

  logic             pop;
  logic             push;
  logic             accept;
  logic             credit;
  logic [CNT_W:0]   inflight;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit counts queued plus in-flight fetches, with this cycle's pop
  // already freeing its slot so 1-cycle memory sustains one instr per cycle.
  assign pop            = if_valid & ~stall & ~redirect;
  assign inflight       = {1'b0, occ_q} + {1'b0, outst_q} - {{CNT_W{1'b0}}, pop};
  assign credit         = inflight < (CNT_W + 1)'(DEPTH);
  assign imem_req_valid = credit & ~redirect & ~reset;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;
  assign push           = imem_rsp_valid & ~redirect & (drop_q == '0);

  assign if_valid = (occ_q != '0);
  assign if_pc    = out_pc_q;
  assign if_instr = out_ins_q;

  // Next-state for PCs, counters, pointers and the registered head view.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    out_pc_d   = out_pc_q;
    out_ins_d  = out_ins_q;
    outst_d    = outst_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

    if (redirect) begin
      // Everything already requested is stale; the response landing now is
      // discarded directly, the rest are counted off as they return.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_d     = outst_q - CNT_W'(imem_rsp_valid);
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + PC_W'(4);
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + PC_W'(4);
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Outputs track the head entry; if the entry is being written this very
    // cycle, forward the incoming response. Empty queue holds the last value.
    if (occ_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        out_pc_d  = rsp_pc_q;
        out_ins_d = imem_rsp_data;
      end else begin
        out_pc_d  = pc_mem_q[rd_ptr_d];
        out_ins_d = ins_mem_q[rd_ptr_d];
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      out_pc_q   <= '0;
      out_ins_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      out_pc_q   <= out_pc_d;
      out_ins_q  <= out_ins_d;
    end
  end

  // Queue storage; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem_q[wr_ptr_q]  <= rsp_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (occ_q == CNT_W'(DEPTH))));

  a_rsp_expected : assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && (outst_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue: instruction memory model
//            with selectable latency, scoreboard of expected PCs, and
//            directed scenarios for stall, redirect, wrap, backpressure, reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [PC_W-1:0]  imem_req_addr;
  logic             imem_rsp_valid;
  logic [INS_W-1:0] imem_rsp_data;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int lat   = 1;

  logic [PC_W-1:0] sb[$];
  logic [PC_W-1:0] exp_fetch;
  logic [3:0]      pipe_v;
  logic [PC_W-1:0] pipe_a [4];

  always #5 clk = ~clk;

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  function automatic logic [INS_W-1:0] instr_of(input logic [PC_W-1:0] a);
    return {16'hC0DE, 7'd0, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [PC_W-1:0] start, input int n);
    logic [PC_W-1:0] a;
    sb.delete();
    a = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back(a);
      a = a + PC_W'(4);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: fixed-latency in-order pipe, cleared by reset.
  always @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[2:0], imem_req_valid & imem_req_ready};
      pipe_a[0] <= imem_req_addr;
      for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign imem_rsp_valid = pipe_v[lat-1];
  assign imem_rsp_data  = instr_of(pipe_a[lat-1]);

  // Reference fetch address progression.
  always @(posedge clk) begin
    if (reset)                                exp_fetch <= '0;
    else if (redirect)                        exp_fetch <= redirect_pc;
    else if (imem_req_valid && imem_req_ready) exp_fetch <= exp_fetch + PC_W'(4);
  end

  // Output monitor: every consumed head is checked against the scoreboard,
  // every presented request address against the reference fetch PC.
  always @(negedge clk) begin
    logic [PC_W-1:0] e;
    if (!reset && imem_req_valid) check("req_addr", 32'(imem_req_addr), 32'(exp_fetch));
    if (!reset && if_valid && !stall && !redirect) begin
      if (sb.size() == 0) begin
        check("sb_size", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("if_pc", 32'(if_pc), 32'(e));
        check("if_instr", if_instr, instr_of(e));
        n_pop++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; lat = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_if_pc", 32'(if_pc), 0);
    check("rst_if_instr", if_instr, 0);

    // ---- start-up latency and stall ----
    sb_load('0, 16);
    step(); reset = 1'b0;
    @(negedge clk);
    check("c0_if_valid", 32'(if_valid), 0);
    check("c0_req_valid", 32'(imem_req_valid), 1);
    step(); @(negedge clk);
    check("c1_if_valid", 32'(if_valid), 0);
    check("c1_req_valid", 32'(imem_req_valid), 1);
    step(); @(negedge clk);
    check("c2_if_valid", 32'(if_valid), 1);
    check("c2_req_valid", 32'(imem_req_valid), 1);
    step(); @(negedge clk);
    check("c3_req_valid", 32'(imem_req_valid), 1);
    step(); stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_if_valid", 32'(if_valid), 1);
      check("stall_if_pc", 32'(if_pc), 32'h008);
      check("stall_if_instr", if_instr, instr_of(9'h008));
      check("stall_req_valid", 32'(imem_req_valid), 0);
      if (k < 2) step();
    end
    step(); stall = 1'b0;
    repeat (6) step();
    stall = 1'b1;
    check("ph1_pops", n_pop, 8);

    // ---- redirect with stale fetches in flight, 2-cycle memory ----
    repeat (4) step();
    lat = 2; stall = 1'b0;
    redirect = 1'b1; redirect_pc = 9'h0A0; sb.delete();
    @(negedge clk);
    check("rd0_req_valid", 32'(imem_req_valid), 0);
    step(); redirect = 1'b0;
    @(negedge clk);
    check("rd1_if_valid", 32'(if_valid), 0);
    check("rd1_req_valid", 32'(imem_req_valid), 1);
    step(); @(negedge clk);
    check("rd2_req_valid", 32'(imem_req_valid), 1);
    step();
    redirect = 1'b1; redirect_pc = 9'h040; sb_load(9'h040, 16);
    @(negedge clk);
    check("rd3_rsp_valid", 32'(imem_rsp_valid), 1);
    check("rd3_if_valid", 32'(if_valid), 0);
    step(); redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drop_if_valid", 32'(if_valid), 0);
      step();
    end
    @(negedge clk);
    check("new_if_valid", 32'(if_valid), 1);
    check("new_if_pc", 32'(if_pc), 32'h040);
    repeat (8) step();

    // ---- wrap redirect, 1-cycle memory ----
    stall = 1'b1;
    repeat (7) step();
    lat = 1; stall = 1'b0;
    redirect = 1'b1; redirect_pc = 9'h1F8; sb_load(9'h1F8, 16);
    @(negedge clk);
    check("wr0_req_valid", 32'(imem_req_valid), 0);
    step(); redirect = 1'b0;
    @(negedge clk);
    check("wr1_if_valid", 32'(if_valid), 0);
    step(); @(negedge clk);
    check("wr2_if_valid", 32'(if_valid), 0);
    step(); @(negedge clk);
    check("wr3_if_valid", 32'(if_valid), 1);
    check("wr3_if_pc", 32'(if_pc), 32'h1F8);
    repeat (6) step();

    // ---- memory backpressure ----
    imem_req_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("bp_req_valid", 32'(imem_req_valid), 1);
      if (j >= 2) check("bp_if_valid", 32'(if_valid), 0);
      step();
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    check("bp5_if_valid", 32'(if_valid), 0);
    step(); @(negedge clk);
    check("bp6_if_valid", 32'(if_valid), 0);
    step(); @(negedge clk);
    check("bp7_if_valid", 32'(if_valid), 1);
    repeat (4) step();

    // ---- reset with a full queue ----
    stall = 1'b1;
    step(); reset = 1'b1;
    @(negedge clk);
    check("rs0_req_valid", 32'(imem_req_valid), 0);
    step(); @(negedge clk);
    check("rs1_if_valid", 32'(if_valid), 0);
    check("rs1_req_valid", 32'(imem_req_valid), 0);
    check("rs1_if_pc", 32'(if_pc), 0);
    check("rs1_if_instr", if_instr, 0);
    stall = 1'b0; sb_load('0, 16);
    step(); reset = 1'b0;
    @(negedge clk);
    check("rs2_if_valid", 32'(if_valid), 0);
    check("rs2_req_valid", 32'(imem_req_valid), 1);
    step(); step(); @(negedge clk);
    check("rs4_if_valid", 32'(if_valid), 1);
    check("rs4_if_pc", 32'(if_pc), 0);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
